fetch_unit: RTL

- Instruction-fetch stage directly downstream of the warp scheduler.
- Accepts one scheduled warp per cycle (wid, tmask, PC, uuid) and issues a word read to the instruction cache.
- Parks per-warp metadata in a wid-indexed tag store, pairs each icache response with it, and emits a fetched-instruction packet to decode.
- At most one fetch in flight per warp (the scheduler holds a warp stalled until decode); total in-flight fetches are bounded by MAX_PENDING.

---
 rtl/fetch_unit_pkg.sv | 38 +++
 rtl/fetch_tag_store.sv | 43 ++++
 rtl/fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_unit_pkg;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int PC_BITS     = 30;
  localparam int UUID_WIDTH  = 44;
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  // Per-warp metadata parked while the icache read is outstanding.
  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
    logic [UUID_WIDTH-1:0]  uuid;
  } fetch_tag_t;

  // Fetched-instruction packet handed to decode.
  typedef struct packed {
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
    logic [31:0]            instr;
    logic [UUID_WIDTH-1:0]  uuid;
  } fetch_pkt_t;

`ifdef FETCH_PERF_EN
  localparam int PERF_CTR_BITS = 44;

  typedef struct packed {
    logic [PERF_CTR_BITS-1:0] stalls;
    logic [PERF_CTR_BITS-1:0] lat;
    logic [PERF_CTR_BITS-1:0] fetches;
  } fetch_perf_t;
`endif

endpackage

// File: rtl/fetch_tag_store.sv
// Warp-indexed metadata store with valid bits; one write port, one read/clear port.
// Latency: combinational read; writes and valid updates land on the next edge.
// Backpressure: none; same-index write+clear in one cycle reads old data, write wins valid.
module fetch_tag_store import fetch_unit_pkg::*; (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [NW_WIDTH-1:0] wr_idx,
  input  fetch_tag_t          wr_dat,
  output logic                wr_busy,
  input  logic                rd_clr,
  input  logic [NW_WIDTH-1:0] rd_idx,
  output fetch_tag_t          rd_dat,
  output logic                rd_vld
);

  fetch_tag_t           mem [NUM_WARPS];
  logic [NUM_WARPS-1:0] tag_vld;

  assign rd_dat  = mem[rd_idx];
  assign rd_vld  = tag_vld[rd_idx];
  assign wr_busy = tag_vld[wr_idx];

  // Metadata array is intentionally not reset; tag_vld qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  // Valid bits: a write sets, a read clears; a same-index write overrides the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (wr_en && (wr_idx == NW_WIDTH'(i)))
          tag_vld[i] <= 1'b1;
        else if (rd_clr && (rd_idx == NW_WIDTH'(i)))
          tag_vld[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo.sv
// Generic elastic FIFO; DEPTH=2 gives a full-throughput skid/elastic buffer.
// Latency: 1 cycle from push to out_vld.
// Backpressure: in_rdy is registered (count < DEPTH), independent of out_rdy.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy  = (count != CNT_W'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: forwards scheduled warps to the icache and pairs responses with warp metadata (FETCH_PERF_EN adds perf counters).
// Latency: request is combinational pass-through; packet is valid one cycle after the icache response fires.
// Backpressure: sched_ready follows icache_req_ready and stalls at MAX_PENDING; icache_rsp_ready follows the 2-entry output buffer.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int MAX_PENDING = NUM_WARPS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [PC_BITS-1:0]     sched_pc,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [PC_BITS-2:0]     icache_req_addr,
  output logic [NW_WIDTH-1:0]    icache_req_tag,
  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [PC_BITS-1:0]     fetch_pc,
  output logic [31:0]            fetch_instr,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  output logic                   busy
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_icache_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_icache_lat,
  output logic [PERF_CTR_BITS-1:0] perf_fetches
`endif
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [CNT_W-1:0] pending_cnt;
  logic             full;
  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_hit;
  logic             rsp_dec;
  logic             buf_in_rdy;
  logic             wr_busy;
  fetch_tag_t       req_meta;
  fetch_tag_t       rsp_meta;
  fetch_pkt_t       rsp_pkt;
  fetch_pkt_t       out_pkt;

  // Request path: straight through to the icache, throttled by outstanding count.
  assign full             = (pending_cnt == CNT_W'(MAX_PENDING));
  assign icache_req_valid = sched_valid && !full;
  assign sched_ready      = icache_req_ready && !full;
  assign req_fire         = sched_valid && sched_ready;
  assign icache_req_addr  = sched_pc[PC_BITS-1:1];
  assign icache_req_tag   = sched_wid;
  assign req_meta         = '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};

  // Response path: a stray tag (no parked metadata) is consumed but not forwarded.
  assign icache_rsp_ready = buf_in_rdy;
  assign rsp_fire         = icache_rsp_valid && buf_in_rdy;
  assign rsp_dec          = rsp_fire && rsp_hit;
  assign rsp_pkt          = '{wid:   icache_rsp_tag,
                              tmask: rsp_meta.tmask,
                              pc:    rsp_meta.pc,
                              instr: icache_rsp_data,
                              uuid:  rsp_meta.uuid};

  fetch_tag_store u_tag_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (req_fire),
    .wr_idx  (sched_wid),
    .wr_dat  (req_meta),
    .wr_busy (wr_busy),
    .rd_clr  (rsp_fire),
    .rd_idx  (icache_rsp_tag),
    .rd_dat  (rsp_meta),
    .rd_vld  (rsp_hit)
  );

  fifo #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (2)
  ) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rsp_fire && rsp_hit),
    .in_rdy  (buf_in_rdy),
    .in_dat  (rsp_pkt),
    .out_vld (fetch_valid),
    .out_rdy (fetch_ready),
    .out_dat (out_pkt)
  );

  assign fetch_wid   = out_pkt.wid;
  assign fetch_tmask = out_pkt.tmask;
  assign fetch_pc    = out_pkt.pc;
  assign fetch_instr = out_pkt.instr;
  assign fetch_uuid  = out_pkt.uuid;
  assign busy        = (pending_cnt != '0) || fetch_valid;

  // Outstanding request count; only matched responses retire an entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_cnt <= '0;
    end else begin
      case ({req_fire, rsp_dec})
        2'b10:   pending_cnt <= pending_cnt + 1'b1;
        2'b01:   pending_cnt <= pending_cnt - 1'b1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_t perf;

  // Stall cycles, summed occupancy (for average latency) and response count.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf <= '0;
    end else begin
      if (sched_valid && !sched_ready) perf.stalls <= perf.stalls + 1'b1;
      perf.lat <= perf.lat + PERF_CTR_BITS'(pending_cnt);
      if (rsp_fire) perf.fetches <= perf.fetches + 1'b1;
    end
  end

  assign perf_icache_stalls = perf.stalls;
  assign perf_icache_lat    = perf.lat;
  assign perf_fetches       = perf.fetches;
`endif

`ifndef NDEBUG
  logic rsp_chk_en;

  // Responses issued before a reset may still trickle in; tolerate them until new traffic starts.
  always_ff @(posedge clk) begin
    if (reset)         rsp_chk_en <= 1'b0;
    else if (req_fire) rsp_chk_en <= 1'b1;
  end

  // Protocol checks: one fetch per warp in flight, responses must match a parked tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(req_fire && wr_busy && !(rsp_fire && (icache_rsp_tag == sched_wid))));
      assert (!(rsp_fire && !rsp_hit && rsp_chk_en));
    end
  end
`endif

endmodule
